demux64_1to2_buf: RTL and testbench

- 64-bit 1-to-2 steering demultiplexer with one registered output slot per destination; the write-side counterpart to the team's 2-to-1 64-bit select muxes.
- Accepts one word per cycle from a single producer and routes it by `in_sel` to output A (sel=0) or output B (sel=1).
- Uses valid/ready handshakes on all three interfaces.
- Sits between the 64-bit HI/LO result path (multiply/divide) and its two consumers.

---
 rtl/demux64_1to2_buf.sv | 109 ++++++++++
 tb/tb_demux64_1to2_buf.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/demux64_1to2_buf.sv
// demux64_1to2_buf
//   1-to-2 steering demultiplexer with a single registered output slot per
//   destination. One producer offers a word per cycle; in_sel picks slot A
//   (0) or slot B (1). Each slot is an independent one-entry buffer that can
//   be drained and reloaded in the same cycle, giving 1 word/cycle per
//   destination. Placed between the 64-bit HI/LO result path and its two
//   consumers.
//
// Parameters
//   WIDTH : data width of input and both outputs (default 64)
//   CNT_W : width of the per-output delivered-word counters
//
// Optional feature
//   DEMUX_CNT_EN : when defined, adds cntA/cntB, which count words delivered
//                  on each output and wrap at 2^CNT_W.
//
// Ports
//   Clk, Rst_n              : clock (rising edge), async active-low reset
//   in_valid/in_ready       : producer handshake
//   in_data, in_sel         : word and destination (0 = A, 1 = B)
//   outA_valid/outA_ready   : consumer A handshake, outA_data slot A word
//   outB_valid/outB_ready   : consumer B handshake, outB_data slot B word
//   cntA, cntB              : delivered-word counters (DEMUX_CNT_EN only)

module demux64_1to2_buf #(
  parameter int WIDTH = 64,
  parameter int CNT_W = 16
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sel,
  output logic             outA_valid,
  input  logic             outA_ready,
  output logic [WIDTH-1:0] outA_data,
  output logic             outB_valid,
  input  logic             outB_ready,
  output logic [WIDTH-1:0] outB_data
`ifdef DEMUX_CNT_EN
  ,
  output logic [CNT_W-1:0] cntA,
  output logic [CNT_W-1:0] cntB
`endif
);

  logic drain_a;
  logic drain_b;
  logic load_a;
  logic load_b;

  assign drain_a = outA_valid & outA_ready;
  assign drain_b = outB_valid & outB_ready;

  // A slot can take a new word when it is empty or is being drained this
  // cycle. in_valid is deliberately kept out of in_ready so the producer may
  // wait on ready without creating a combinational loop.
  assign in_ready = in_sel ? (~outB_valid | outB_ready)
                           : (~outA_valid | outA_ready);

  assign load_a = in_valid & in_ready & ~in_sel;
  assign load_b = in_valid & in_ready &  in_sel;

  // Slot A. Load has priority over drain so a simultaneous drain+load keeps
  // valid high with the new word.
  // NOTE: sequential state is written with non-blocking assignments so every
  // register samples pre-edge values regardless of statement order.
  // NOTE: the data registers are reset as well, because outputs must read 0
  // immediately after reset, not merely be flagged invalid.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      outA_valid <= 1'b0;
      outA_data  <= '0;
    end else if (load_a) begin
      outA_valid <= 1'b1;
      outA_data  <= in_data;
    end else if (drain_a) begin
      outA_valid <= 1'b0;
    end
  end

  // Slot B, identical and fully independent of slot A.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      outB_valid <= 1'b0;
      outB_data  <= '0;
    end else if (load_b) begin
      outB_valid <= 1'b1;
      outB_data  <= in_data;
    end else if (drain_b) begin
      outB_valid <= 1'b0;
    end
  end

`ifdef DEMUX_CNT_EN
  // Delivered-word counters; natural binary wrap at 2^CNT_W.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      cntA <= '0;
      cntB <= '0;
    end else begin
      if (drain_a) cntA <= cntA + 1'b1;
      if (drain_b) cntB <= cntB + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_demux64_1to2_buf.sv
// tb_demux64_1to2_buf
//   Directed self-checking bench for demux64_1to2_buf. Inputs are driven and
//   outputs sampled 1 time unit after the rising edge, well away from it.

module tb_demux64_1to2_buf;

  localparam int WIDTH = 64;
  localparam int CNT_W = 4;

  logic             Clk;
  logic             Rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_sel;
  logic             outA_valid;
  logic             outA_ready;
  logic [WIDTH-1:0] outA_data;
  logic             outB_valid;
  logic             outB_ready;
  logic [WIDTH-1:0] outB_data;
`ifdef DEMUX_CNT_EN
  logic [CNT_W-1:0] cntA;
  logic [CNT_W-1:0] cntB;
`endif

  int tests_run;
  int tests_failed;

  demux64_1to2_buf #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) dut (
    .Clk        (Clk),
    .Rst_n      (Rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_sel     (in_sel),
    .outA_valid (outA_valid),
    .outA_ready (outA_ready),
    .outA_data  (outA_data),
    .outB_valid (outB_valid),
    .outB_ready (outB_ready),
    .outB_data  (outB_data)
`ifdef DEMUX_CNT_EN
    ,
    .cntA       (cntA),
    .cntB       (cntB)
`endif
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    Rst_n      = 1'b0;
    in_valid   = 1'b0;
    in_data    = '0;
    in_sel     = 1'b0;
    outA_ready = 1'b0;
    outB_ready = 1'b0;

    // ---- Reset and first word ----
    repeat (3) step();
    check("rst_a_valid", outA_valid, 0);
    check("rst_b_valid", outB_valid, 0);
    check("rst_a_data",  outA_data,  0);
    check("rst_b_data",  outB_data,  0);
    check("rst_in_ready", in_ready,  1);
    Rst_n    = 1'b1;
    in_valid = 1'b1;
    in_sel   = 1'b0;
    in_data  = 64'h0123_4567_89AB_CDEF;
    #1;
    check("first_in_ready", in_ready, 1);
    step();
    in_valid = 1'b0;
    check("first_a_valid", outA_valid, 1);
    check("first_a_data",  outA_data,  64'h0123_4567_89AB_CDEF);
    check("first_b_valid", outB_valid, 0);
    // Drain A.
    outA_ready = 1'b1;
    step();
    outA_ready = 1'b0;
    check("first_a_drained", outA_valid, 0);

    // ---- Backpressure on B ----
    in_valid = 1'b1;
    in_sel   = 1'b1;
    in_data  = 64'hDEAD_BEEF_0000_0001;
    step();
    check("bp_b_loaded", outB_data, 64'hDEAD_BEEF_0000_0001);
    in_data = 64'h2;
    #1;
    check("bp_in_ready_low", in_ready, 0);
    for (int i = 0; i < 5; i++) begin
      step();
      check("bp_b_hold_data",  outB_data,  64'hDEAD_BEEF_0000_0001);
      check("bp_b_hold_valid", outB_valid, 1);
      check("bp_in_ready_stall", in_ready, 0);
    end
    outB_ready = 1'b1;
    #1;
    check("bp_in_ready_rise", in_ready, 1);
    step();
    in_valid = 1'b0;
    check("bp_b_new_data",  outB_data,  64'h2);
    check("bp_b_new_valid", outB_valid, 1);
    step();
    outB_ready = 1'b0;
    check("bp_b_drained", outB_valid, 0);

    // ---- Streaming on A ----
    outA_ready = 1'b1;
    in_sel     = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b1;
      in_data  = 64'(i);
      #1;
      check("stream_in_ready", in_ready, 1);
      step();
      check("stream_a_data",  outA_data,  64'(i));
      check("stream_a_valid", outA_valid, 1);
      check("stream_b_idle",  outB_valid, 0);
    end
    in_valid = 1'b0;
    step();
    check("stream_a_drained", outA_valid, 0);

    // ---- Independence: A stalled, B streams ----
    outA_ready = 1'b0;
    in_valid   = 1'b1;
    in_sel     = 1'b0;
    in_data    = 64'h55;
    step();
    check("ind_a_loaded", outA_data, 64'h55);
    outB_ready = 1'b1;
    in_sel     = 1'b1;
    in_data    = 64'hA;
    #1;
    check("ind_in_ready_a", in_ready, 1);
    step();
    check("ind_b_data_a", outB_data, 64'hA);
    in_data = 64'hB;
    #1;
    check("ind_in_ready_b", in_ready, 1);
    step();
    in_valid   = 1'b0;
    outB_ready = 1'b0;
    check("ind_b_data_b",  outB_data,  64'hB);
    check("ind_b_valid",   outB_valid, 1);
    check("ind_a_data",    outA_data,  64'h55);
    check("ind_a_valid",   outA_valid, 1);

    // ---- Async reset mid-flight (both slots full) ----
    #2;
    Rst_n = 1'b0;
    #1;
    check("arst_a_valid", outA_valid, 0);
    check("arst_b_valid", outB_valid, 0);
    check("arst_a_data",  outA_data,  0);
    check("arst_b_data",  outB_data,  0);
    #1;
    Rst_n = 1'b1;
    step();

`ifdef DEMUX_CNT_EN
    // ---- Counter wrap: 17 drains on A, 3 on B ----
    check("cnt_a_reset", cntA, 0);
    check("cnt_b_reset", cntB, 0);
    outA_ready = 1'b1;
    outB_ready = 1'b1;
    in_valid   = 1'b1;
    in_sel     = 1'b0;
    for (int i = 0; i < 17; i++) begin
      in_data = 64'(i);
      step();
    end
    in_sel = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_data = 64'(i);
      step();
    end
    in_valid = 1'b0;
    step();
    check("cnt_a_wrap", cntA, 1);
    check("cnt_b",      cntB, 3);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
